pcard_dealer: RTL

//  Deals and scores the player's blackjack hand, one card per clk_sec tick, from a

---
 rtl/pcard_dealer_if.sv | 25 ++
 rtl/pcard_dealer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pcard_dealer_if.sv
// Player-hand bus between the game controller/display side and pcard_dealer.
// master drives the requests and the test hook; slave returns the hand state.
interface pcard_dealer_if;
  logic       deal;
  logic       hit;
  logic       stand;
  logic       force_en;
  logic [5:0] force_card;
  logic [5:0] card1;
  logic [5:0] card2;
  logic [2:0] card_count;
  logic [4:0] hand_value;
  logic       bust;
  logic       done;

  modport master (
    output deal, hit, stand, force_en, force_card,
    input  card1, card2, card_count, hand_value, bust, done
  );

  modport slave (
    input  deal, hit, stand, force_en, force_card,
    output card1, card2, card_count, hand_value, bust, done
  );
endinterface

// File: rtl/pcard_dealer.sv
// Deals and scores the player's blackjack hand from a duplicate-free 52-card deck,
// one card per clk_sec tick, with random draws taken from a free-running LFSR.
//
// state | meaning
// IDLE  | after reset, waiting for the first deal
// DRAW1 | drawing the first card of the hand
// DRAW2 | drawing the second card; a natural 21 ends the hand
// PLAY  | waiting for hit or stand
// DRAWH | drawing a hit card
// DONE  | hand finished; a deal clears the hand and starts over
module pcard_dealer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_CARDS = 5
) (
  input  logic           clk_sec,
  input  logic           rst,
  pcard_dealer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DRAW1, DRAW2, PLAY, DRAWH, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic        deal_q, hit_q, stand_q;
  logic        deal_edge, hit_edge, stand_edge;

  logic [5:0]  card1, card2;
  logic [2:0]  count;
  logic [51:0] used;
  logic [5:0]  hard;
  logic        ace_held;
  logic        bust;

  logic [5:0]  cand;
  logic [3:0]  rank;
  logic [1:0]  suit;
  logic        rank_ok, cand_ok;
  logic [5:0]  idx, pts;
  logic [5:0]  new_hard, new_val, cur_val;
  logic        new_ace;
  logic [2:0]  count_nxt;
  logic        drawing, accept, clear;

  // Soft ace counts 11 only while that keeps the hand at or under 21.
  function automatic logic [5:0] best_value(input logic [5:0] h, input logic a);
    return (a && h <= 6'd11) ? h + 6'd10 : h;
  endfunction

  assign deal_edge  = bus.deal  & ~deal_q;
  assign hit_edge   = bus.hit   & ~hit_q;
  assign stand_edge = bus.stand & ~stand_q;

  assign cand          = bus.force_en ? bus.force_card : lfsr[5:0];
  assign {suit, rank}  = cand;
  assign rank_ok       = (rank != 4'd0) && (rank <= 4'd13);
  assign idx           = 6'(suit) * 6'd13 + 6'(rank) - 6'd1;
  assign cand_ok       = rank_ok && !used[idx];
  assign accept        = drawing && cand_ok;
  assign pts           = (rank > 4'd10) ? 6'd10 : 6'(rank);
  assign new_hard      = hard + pts;
  assign new_ace       = ace_held | (rank == 4'd1);
  assign new_val       = best_value(new_hard, new_ace);
  assign cur_val       = best_value(hard, ace_held);
  assign count_nxt     = count + 3'd1;

  assign bus.card1      = card1;
  assign bus.card2      = card2;
  assign bus.card_count = count;
  assign bus.hand_value = cur_val[4:0];
  assign bus.bust       = bust;

  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      lfsr    <= SEED;
      deal_q  <= 1'b0;
      hit_q   <= 1'b0;
      stand_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      deal_q  <= bus.deal;
      hit_q   <= bus.hit;
      stand_q <= bus.stand;
    end
  end

  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (deal_edge) state_nxt = DRAW1;
      DRAW1: if (accept) state_nxt = DRAW2;
      DRAW2: if (accept) state_nxt = (new_val == 6'd21) ? DONE : PLAY;
      PLAY: begin
        if (stand_edge)    state_nxt = DONE;
        else if (hit_edge) state_nxt = DRAWH;
      end
      DRAWH: if (accept)
        state_nxt = (new_val > 6'd21 || count_nxt == 3'(MAX_CARDS)) ? DONE : PLAY;
      DONE:  if (deal_edge) state_nxt = DRAW1;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    drawing  = 1'b0;
    clear    = 1'b0;
    bus.done = 1'b0;
    case (state)
      DRAW1, DRAW2, DRAWH: drawing = 1'b1;
      DONE: begin
        bus.done = 1'b1;
        clear    = deal_edge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      card1    <= '0;
      card2    <= '0;
      count    <= '0;
      used     <= '0;
      hard     <= '0;
      ace_held <= 1'b0;
      bust     <= 1'b0;
    end else if (clear) begin
      card1    <= '0;
      card2    <= '0;
      count    <= '0;
      used     <= '0;
      hard     <= '0;
      ace_held <= 1'b0;
      bust     <= 1'b0;
    end else if (accept) begin
      card1     <= card2;
      card2     <= cand;
      used[idx] <= 1'b1;
      count     <= count_nxt;
      hard      <= new_hard;
      ace_held  <= new_ace;
      bust      <= (new_val > 6'd21);
    end
  end

endmodule
